// File: rtl/srt4_pkg.sv
// Shared definitions for the SRT radix-4 divider front end: FSM encoding,
// response error codes and the requester-id width helper.
package srt4_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_BUSY  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/srt4_rr_arbiter.sv
// Round-robin picker: grants the first requesting index at or after ptr,
// wrapping to the lowest requesting index when nothing lies above ptr.
module srt4_rr_arbiter
    import srt4_pkg::*;
#(
    parameter int  NREQ = 2,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [NREQ-1:0] req_hi;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign req_hi[gi] = req[gi] && (32'(gi) >= 32'(ptr));
        assign grant[gi]  = grant_any && (grant_idx == IDW'(gi));
    end

    // Scanning downward leaves the lowest matching index; the masked pass overrides the wrap pass.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx = IDW'(i);
                grant_any = 1'b1;
            end
        end
        if (|req_hi) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req_hi[i]) grant_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/srt4_div_arbiter.sv
// Shares one SRT radix-4 divider core among NREQ requesters: round-robin grant,
// local divide-by-zero rejection, hung-core watchdog and tagged responses.
module srt4_div_arbiter
    import srt4_pkg::*;
#(
    parameter int  NREQ    = 2,
    parameter int  WIDTH   = WIDTH_DEF,
    parameter int  TIMEOUT = 64,
    localparam int IDW     = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  div_begin,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_end,
    input  logic [WIDTH-1:0]      div_quot,
    input  logic [WIDTH-1:0]      div_rem,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quot,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic [1:0]            rsp_err,
    output logic [15:0]           ops_done
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t           state_reg, state_next;
    logic [IDW-1:0]   ptr_reg;
    logic [WDW-1:0]   wd_reg;
    logic [WIDTH-1:0] div_dividend_reg, div_divisor_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [WIDTH-1:0] rsp_quot_reg, rsp_rem_reg;
    logic [1:0]       rsp_err_reg;
    logic [15:0]      ops_done_reg;

    logic [WIDTH-1:0] dividend_arr [NREQ];
    logic [WIDTH-1:0] divisor_arr  [NREQ];
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             wd_expired;
    logic             sel_div0;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign dividend_arr[gi] = req_dividend[gi*WIDTH +: WIDTH];
        assign divisor_arr[gi]  = req_divisor[gi*WIDTH +: WIDTH];
    end

    srt4_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Final BUSY cycle is the TIMEOUT-th one; div_end in that cycle still takes priority.
    assign wd_expired = (wd_reg == WDW'(TIMEOUT - 1));
    assign sel_div0   = (divisor_arr[grant_idx] == '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (|req_valid) state_next = ST_GRANT;
            ST_GRANT: begin
                if (!grant_any)    state_next = ST_IDLE;
                else if (sel_div0) state_next = ST_RESP;
                else               state_next = ST_LOAD;
            end
            ST_LOAD:  state_next = ST_BUSY;
            ST_BUSY:  if (div_end || wd_expired) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == ST_GRANT) ? grant : '0;
        div_begin = (state_reg == ST_LOAD);
        rsp_valid = (state_reg == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_reg          <= '0;
            wd_reg           <= '0;
            div_dividend_reg <= '0;
            div_divisor_reg  <= '0;
            rsp_id_reg       <= '0;
            rsp_quot_reg     <= '0;
            rsp_rem_reg      <= '0;
            rsp_err_reg      <= ERR_OK;
            ops_done_reg     <= '0;
        end else begin
            case (state_reg)
                ST_GRANT: if (grant_any) begin
                    div_dividend_reg <= dividend_arr[grant_idx];
                    div_divisor_reg  <= divisor_arr[grant_idx];
                    rsp_id_reg       <= grant_idx;
                    ptr_reg          <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                    if (sel_div0) begin
                        rsp_err_reg  <= ERR_DIV0;
                        rsp_quot_reg <= '1;
                        rsp_rem_reg  <= dividend_arr[grant_idx];
                    end
                end
                ST_LOAD: wd_reg <= '0;
                ST_BUSY: begin
                    wd_reg <= wd_reg + WDW'(1);
                    if (div_end) begin
                        rsp_err_reg  <= ERR_OK;
                        rsp_quot_reg <= div_quot;
                        rsp_rem_reg  <= div_rem;
                    end else if (wd_expired) begin
                        rsp_err_reg  <= ERR_TMO;
                        rsp_quot_reg <= '0;
                        rsp_rem_reg  <= '0;
                    end
                end
                ST_RESP: if (rsp_ready && ops_done_reg != 16'hFFFF) ops_done_reg <= ops_done_reg + 16'd1;
                default: ;
            endcase
        end
    end

    assign div_dividend = div_dividend_reg;
    assign div_divisor  = div_divisor_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_quot     = rsp_quot_reg;
    assign rsp_rem      = rsp_rem_reg;
    assign rsp_err      = rsp_err_reg;
    assign ops_done     = ops_done_reg;

endmodule

// File: tb/tb_srt4_div_arbiter.sv
// Scoreboard bench for srt4_div_arbiter: directed requests push expected responses,
// a monitor pops on each response handshake, a behavioural core answers div_begin.
module tb_srt4_div_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 8;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*W-1:0] req_dividend = '0;
    logic [NREQ*W-1:0] req_divisor = '0;
    logic            div_begin;
    logic [W-1:0]    div_dividend, div_divisor;
    logic            div_end = 1'b0;
    logic [W-1:0]    div_quot = '0, div_rem = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [0:0]      rsp_id;
    logic [W-1:0]    rsp_quot, rsp_rem;
    logic [1:0]      rsp_err;
    logic [15:0]     ops_done;

    srt4_div_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(64)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_begin(div_begin), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_end(div_end), .div_quot(div_quot), .div_rem(div_rem),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0]   id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [1:0]   err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   core_lat = 3;
    bit   core_hang = 1'b0;
    int   begin_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input int id, input int q, input int r, input logic [1:0] err);
        rsp_t e;
        e.id = 1'(id); e.q = W'(q); e.r = W'(r); e.err = err;
        exp_q.push_back(e);
        $display("expect  id=%0d quot=%0d rem=%0d err=%b", id, q, r, err);
    endtask

    // Response monitor: one line per response handshake.
    initial forever begin
        @(negedge clk);
        if (rst_b && rsp_valid && rsp_ready) begin
            $display("rsp     id=%0d quot=%0d rem=%0d err=%b ops_done=%0d", rsp_id, rsp_quot, rsp_rem, rsp_err, ops_done);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rsp actual id=%0d required none", rsp_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id",   32'(rsp_id),   32'(mon_e.id));
                chk("rsp_quot", 32'(rsp_quot), 32'(mon_e.q));
                chk("rsp_rem",  32'(rsp_rem),  32'(mon_e.r));
                chk("rsp_err",  32'(rsp_err),  32'(mon_e.err));
            end
        end
    end

    // Behavioural divider core answering div_begin after core_lat BUSY cycles.
    initial begin
        logic [W-1:0] cap_a, cap_b;
        bit stable_ok, aborted;
        int n;
        forever begin
            @(negedge clk);
            if (div_begin && rst_b) begin
                begin_count++;
                cap_a = div_dividend; cap_b = div_divisor;
                $display("core    begin a=%0d b=%0d", cap_a, cap_b);
                if (core_hang) begin
                    n = 0;
                    while (!rsp_valid && n < 200 && rst_b) begin @(negedge clk); n++; end
                    if (rst_b) chk("tmo_latency", 32'(n), 32'd65);
                end else begin
                    stable_ok = 1'b1; aborted = 1'b0;
                    for (int k = 1; k <= core_lat; k++) begin
                        @(negedge clk);
                        if (!rst_b) aborted = 1'b1;
                        if (!aborted) begin
                            if (div_dividend !== cap_a || div_divisor !== cap_b) stable_ok = 1'b0;
                            if (k == 1) chk("begin_pulse_width", 32'(div_begin), 32'd0);
                        end
                    end
                    if (!aborted) begin
                        chk("operands_stable", 32'(stable_ok), 32'd1);
                        div_end = 1'b1; div_quot = cap_a / cap_b; div_rem = cap_a % cap_b;
                        @(negedge clk);
                        div_end = 1'b0;
                        if (core_lat <= 64) chk("rsp_latency", 32'(rsp_valid), 32'd1);
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int id);
        int n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[id] && n < 500);
        if (!req_ready[id]) begin
            checks++; failures++;
            $display("FAIL grant_wait id=%0d actual no req_ready required req_ready", id);
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[id*W +: W] = a;
        req_divisor[id*W +: W]  = b;
        req_valid[id] = 1'b1;
        $display("req     id=%0d dividend=%0d divisor=%0d", id, a, b);
        wait_ready(id);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || rsp_valid) && n < 400);
        if (exp_q.size() != 0 || rsp_valid) begin
            checks++; failures++;
            $display("FAIL drain actual pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit actual expired required finish");
        $fatal(1, "time limit");
    end

    initial begin
        int b0, n;
        logic [7:0] t2a0 [3], t2b0 [3], t2a1 [3], t2b1 [3];

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_state", {req_ready, div_begin, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, ops_done},
            32'd0);
        @(posedge clk); #1; rst_b = 1'b1;

        // 1: req0 100/7 -> 14 r2
        push_exp(0, 14, 2, 2'b00);
        b0 = begin_count;
        issue(0, 8'd100, 8'd7);
        wait_idle();
        chk("t1_begin_count", 32'(begin_count - b0), 32'd1);
        chk("t1_ops_done", 32'(ops_done), 32'd1);

        // 3: req1 50/0 -> local reject, response the cycle after grant
        push_exp(1, 255, 50, 2'b01);
        b0 = begin_count;
        req_dividend[W +: W] = 8'd50; req_divisor[W +: W] = 8'd0; req_valid[1] = 1'b1;
        $display("req     id=1 dividend=50 divisor=0");
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[1] && n < 100);
        chk("t3_grant", 32'(req_ready), 32'b10);
        @(posedge clk); #1; req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t3_div0_latency", 32'(rsp_valid), 32'd1);
        wait_idle();
        chk("t3_no_begin", 32'(begin_count - b0), 32'd0);

        // 2: both valid continuously, grants alternate starting at 0
        t2a0 = '{8'd200, 8'd99, 8'd255}; t2b0 = '{8'd10, 8'd9, 8'd16};
        t2a1 = '{8'd45, 8'd17, 8'd8};    t2b1 = '{8'd6, 8'd5, 8'd3};
        push_exp(0, 20, 0, 2'b00);  push_exp(1, 7, 3, 2'b00);
        push_exp(0, 11, 0, 2'b00);  push_exp(1, 3, 2, 2'b00);
        push_exp(0, 15, 15, 2'b00); push_exp(1, 2, 2, 2'b00);
        fork
            begin for (int j = 0; j < 3; j++) issue(0, t2a0[j], t2b0[j]); end
            begin for (int j = 0; j < 3; j++) issue(1, t2a1[j], t2b1[j]); end
        join
        wait_idle();
        chk("t2_ops_done", 32'(ops_done), 32'd8);

        // 4: hung core -> timeout; then normal op; then div_end on cycle 64 / 65
        core_hang = 1'b1;
        push_exp(0, 0, 0, 2'b10);
        issue(0, 8'd77, 8'd7);
        wait_idle();
        core_hang = 1'b0;
        push_exp(1, 11, 0, 2'b00);
        issue(1, 8'd77, 8'd7);
        wait_idle();
        core_lat = 64;
        push_exp(0, 9, 3, 2'b00);
        issue(0, 8'd84, 8'd9);
        wait_idle();
        core_lat = 65;
        push_exp(1, 0, 0, 2'b10);
        issue(1, 8'd10, 8'd2);
        wait_idle();
        repeat (3) @(negedge clk);
        core_lat = 3;

        // 5: consumer stall with another request pending
        rsp_ready = 1'b0;
        push_exp(0, 15, 0, 2'b00);
        issue(0, 8'd60, 8'd4);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        push_exp(1, 6, 0, 2'b00);
        req_dividend[W +: W] = 8'd30; req_divisor[W +: W] = 8'd5; req_valid[1] = 1'b1;
        $display("req     id=1 dividend=30 divisor=5 (pending during stall)");
        b0 = begin_count;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t5_stall_hold", {rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, req_ready, div_begin},
                {1'b1, 1'b0, 8'd15, 8'd0, 2'b00, 2'b00, 1'b0});
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        wait_ready(1);
        req_valid[1] = 1'b0;
        wait_idle();
        chk("t5_begin_count", 32'(begin_count - b0), 32'd1);

        // 6: reset during BUSY abandons the op and clears the pointer
        core_lat = 20;
        b0 = begin_count;
        issue(0, 8'd90, 8'd9);
        n = 0;
        while (begin_count == b0 && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        @(posedge clk); #1; rst_b = 1'b0;
        @(negedge clk);
        chk("t6_reset_outputs", {req_ready, div_begin, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, ops_done},
            32'd0);
        chk("t6_reset_operands", {div_dividend, div_divisor}, 32'd0);
        @(posedge clk); #1; rst_b = 1'b1;
        core_lat = 3;
        repeat (25) @(negedge clk);
        chk("t6_no_response", 32'(rsp_valid), 32'd0);
        push_exp(0, 5, 0, 2'b00);
        push_exp(1, 4, 1, 2'b00);
        fork
            issue(0, 8'd25, 8'd5);
            issue(1, 8'd9, 8'd2);
        join
        wait_idle();
        chk("t6_ops_done", 32'(ops_done), 32'd2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
